// File: rtl/em_sequencer_if.sv
// Tile-controller and edge-memory handshake for em_sequencer.
// The master drives the run request and per-node hold flags; the slave drives the memory controls and status.
interface em_sequencer_if #(
    parameter int NEM  = 4,
    parameter int SELW = 3,
    parameter int CW   = 16
);
    logic                START;
    logic [CW-1:0]       CYCLES;
    logic [NEM-1:0]      HOLD;
    logic [NEM-1:0]      SHIFT_EN;
    logic                INIT;
    logic [NEM*SELW-1:0] SEL;
    logic                BUSY;
    logic                DONE;
    logic [CW-1:0]       ITER;

    modport master (
        output START, CYCLES, HOLD,
        input  SHIFT_EN, INIT, SEL, BUSY, DONE, ITER
    );

    modport slave (
        input  START, CYCLES, HOLD,
        output SHIFT_EN, INIT, SEL, BUSY, DONE, ITER
    );
endinterface

// File: rtl/em_sequencer.sv
// Edge-memory sequencer: preloads every memory for N cycles, then runs CYCLES decode cycles
// with hold-gated shifting and a fresh LFSR-derived tap select per cycle.
//
// state | meaning
// IDLE  | waiting for START; ITER/SEL keep last run's values
// INIT  | N cycles, all memories shift in the preload stream
// RUN   | latched-count cycles, SHIFT_EN = ~HOLD, LFSR advances every cycle
// FIN   | one-cycle DONE pulse, START ignored
module em_sequencer #(
    parameter int          N    = 8,
    parameter int          SELW = 3,
    parameter int          NEM  = 4,
    parameter int          CW   = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic           CLK,
    input  logic           RESET,
    em_sequencer_if.slave  bus
);

    localparam int          SW       = NEM * SELW;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [SELW-1:0] PH_LAST = SELW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] phase_q, phase_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   iter_q, iter_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            init_q, init_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            run_q, run_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        iter_d  = iter_q;
        lfsr_d  = lfsr_q;
        sel_d   = sel_q;
        init_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        run_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_INIT;
                    count_d = bus.CYCLES;
                    phase_d = '0;
                    lfsr_d  = SEED_EFF;
                    iter_d  = '0;
                    init_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_INIT: begin
                if (phase_q == PH_LAST) begin
                    if (count_q != '0) begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                        busy_d  = 1'b1;
                        sel_d   = lfsr_q[SW-1:0];
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    init_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // The LFSR steps even for held memories so every tap stays decorrelated.
                lfsr_d = lfsr_step(lfsr_q);
                iter_d = iter_q + 1'b1;
                if (iter_d == count_q) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    run_d  = 1'b1;
                    busy_d = 1'b1;
                    sel_d  = lfsr_d[SW-1:0];
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            count_q <= '0;
            iter_q  <= '0;
            lfsr_q  <= SEED_EFF;
            sel_q   <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            iter_q  <= iter_d;
            lfsr_q  <= lfsr_d;
            sel_q   <= sel_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    // HOLD gates the shift within the same cycle, so no registered lag on SHIFT_EN in RUN.
    assign bus.SHIFT_EN = run_q ? ~bus.HOLD : {NEM{init_q}};
    assign bus.INIT     = init_q;
    assign bus.SEL      = sel_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ITER     = iter_q;

endmodule

// File: tb/tb_em_sequencer.sv
// Self-checking bench for em_sequencer: constant vector table for the basic run,
// timeline model plus expectation queue for the remaining scenarios.
module tb_em_sequencer;

    localparam int N = 8;

    logic CLK;
    logic RESET;

    em_sequencer_if #(.NEM(4), .SELW(3), .CW(16)) bus ();

    em_sequencer #(.N(8), .SELW(3), .NEM(4), .CW(16), .SEED(16'hACE1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] cyc;
        logic [3:0]  hold;
        logic [3:0]  shift;
        logic        init;
        logic        busy;
        logic        done;
        logic [11:0] sel;
        logic [15:0] iter;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[14];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    // Timeline model: m_k counts cycles since the accepted START.
    bit          m_act;
    int          m_k;
    int          m_cnt;
    logic [15:0] m_lfsr;
    logic [11:0] m_sel;
    logic [15:0] m_iter;

    function automatic vec_t mk(input logic rst, input logic start, input logic [15:0] cyc,
                                input logic [3:0] hold, input logic [3:0] sh, input logic in,
                                input logic bu, input logic dn, input logic [11:0] sel,
                                input logic [15:0] it);
        vec_t v;
        v.rst = rst; v.start = start; v.cyc = cyc; v.hold = hold;
        v.shift = sh; v.init = in; v.busy = bu; v.done = dn; v.sel = sel; v.iter = it;
        return v;
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic vec_t model_exp(input logic rst, input logic start, input logic [15:0] cyc,
                                       input logic [3:0] hold);
        vec_t v;
        v = mk(rst, start, cyc, hold, 4'h0, 1'b0, 1'b0, 1'b0, m_sel, m_iter);
        if (m_act) begin
            if (m_k <= N) begin
                v.shift = 4'hF; v.init = 1'b1; v.busy = 1'b1;
            end else if (m_k <= N + m_cnt) begin
                v.shift = ~hold; v.busy = 1'b1; v.sel = m_lfsr[11:0];
                v.iter = 16'(m_k - N - 1);
            end else begin
                v.done = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic model_edge(input logic rst, input logic start, input logic [15:0] cyc);
        if (rst) begin
            m_act = 0; m_iter = '0; m_sel = '0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_k = 1; m_cnt = int'(cyc); m_lfsr = 16'hACE1; m_iter = '0;
            end
        end else begin
            if (m_k > N && m_k <= N + m_cnt) begin
                m_sel  = m_lfsr[11:0];
                m_lfsr = adv(m_lfsr);
                m_iter = m_iter + 16'd1;
            end
            if (m_k == N + m_cnt + 1) m_act = 0;
            else m_k++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge CLK);
        RESET      = v.rst;
        bus.START  = v.start;
        bus.CYCLES = v.cyc;
        bus.HOLD   = v.hold;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("shift_en[%0d]", step), 32'(bus.SHIFT_EN), 32'(e.shift));
        chk($sformatf("init[%0d]", step),     32'(bus.INIT),     32'(e.init));
        chk($sformatf("busy[%0d]", step),     32'(bus.BUSY),     32'(e.busy));
        chk($sformatf("done[%0d]", step),     32'(bus.DONE),     32'(e.done));
        chk($sformatf("sel[%0d]", step),      32'(bus.SEL),      32'(e.sel));
        chk($sformatf("iter[%0d]", step),     32'(bus.ITER),     32'(e.iter));
        model_edge(v.rst, v.start, v.cyc);
        step++;
    endtask

    task automatic mstep(input logic rst, input logic start, input logic [15:0] cyc,
                         input logic [3:0] hold);
        run_vec(model_exp(rst, start, cyc, hold));
    endtask

    initial begin
        int n;
        RESET = 1'b1; bus.START = 1'b0; bus.CYCLES = '0; bus.HOLD = '0;
        repeat (2) @(posedge CLK);
        model_edge(1'b1, 1'b0, 16'd0);

        // reset then idle
        mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 0);

        // basic run, CYCLES=3: constants worked out by hand
        tbl[0] = mk(0, 1, 16'd3, 4'h0, 4'h0, 0, 0, 0, 12'h000, 16'd0);
        for (int i = 1; i <= 8; i++)
            tbl[i] = mk(0, 0, 16'd0, 4'h0, 4'hF, 1, 1, 0, 12'h000, 16'd0);
        tbl[9]  = mk(0, 0, 16'd0, 4'h0, 4'hF, 0, 1, 0, 12'hCE1, 16'd0);
        tbl[10] = mk(0, 0, 16'd0, 4'h0, 4'hF, 0, 1, 0, 12'h270, 16'd1);
        tbl[11] = mk(0, 0, 16'd0, 4'h0, 4'hF, 0, 1, 0, 12'h138, 16'd2);
        tbl[12] = mk(0, 0, 16'd0, 4'h0, 4'h0, 0, 0, 1, 12'h138, 16'd3);
        tbl[13] = mk(0, 0, 16'd0, 4'h0, 4'h0, 0, 0, 0, 12'h138, 16'd3);
        for (int i = 0; i < 14; i++) run_vec(tbl[i]);

        // hold gating with stray STARTs during INIT, RUN and FIN
        mstep(0, 1, 16'd3, 0);
        for (int i = 1; i <= 8; i++) mstep(0, (i == 3), 16'd7, 0);
        mstep(0, 1, 16'd7, 4'b0101);
        chk("hold_gate", 32'(bus.SHIFT_EN), 32'h0000000A);
        mstep(0, 0, 16'd0, 4'b0000);
        chk("hold_no_lag", 32'(bus.SHIFT_EN), 32'h0000000F);
        chk("hold_lfsr_adv", 32'(bus.SEL), 32'h00000270);
        mstep(0, 0, 16'd0, 4'b0011);
        mstep(0, 1, 16'd9, 0);
        chk("fin_start_ignored_done", 32'(bus.DONE), 32'd1);
        // back-to-back START in the idle cycle after FIN
        mstep(0, 1, 16'd2, 0);
        for (int i = 1; i <= 8; i++) mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 0);
        chk("restart_sel", 32'(bus.SEL), 32'h00000CE1);
        mstep(0, 0, 0, 4'b1000);
        mstep(0, 0, 0, 0);
        chk("run2_iter", 32'(bus.ITER), 32'd2);
        mstep(0, 0, 0, 0);

        // zero cycles: DONE at t+9, SEL left as it was
        mstep(0, 1, 16'd0, 0);
        for (int i = 1; i <= 8; i++) mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 0);
        chk("zero_done", 32'(bus.DONE), 32'd1);
        chk("zero_sel_kept", 32'(bus.SEL), 32'h00000270);
        mstep(0, 0, 0, 0);

        // reset in 2nd RUN cycle, then reproducible rerun
        mstep(0, 1, 16'd5, 0);
        for (int i = 1; i <= 8; i++) mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 4'b0110);
        mstep(1, 0, 0, 0);
        mstep(0, 0, 0, 0);
        chk("abort_no_done", 32'(bus.DONE), 32'd0);
        mstep(0, 0, 0, 0);
        mstep(0, 1, 16'd3, 0);
        for (int i = 1; i <= 8; i++) mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 0);
        chk("rerun_sel0", 32'(bus.SEL), 32'h00000CE1);
        mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 0);
        chk("rerun_sel2", 32'(bus.SEL), 32'h00000138);
        mstep(0, 0, 0, 0);
        mstep(0, 0, 0, 0);

        // all-ones count: latency N+count+1 and ITER ends at 2**CW-1
        @(negedge CLK);
        bus.START = 1'b1; bus.CYCLES = 16'hFFFF; bus.HOLD = 4'h0;
        @(negedge CLK);
        bus.START = 1'b0;
        n = 1;
        while (!bus.DONE && n < 70000) begin
            @(negedge CLK);
            n++;
        end
        chk("sat_latency", 32'(n), 32'd65544);
        chk("sat_iter", 32'(bus.ITER), 32'h0000FFFF);
        chk("sat_busy", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        chk("sat_iter_hold", 32'(bus.ITER), 32'h0000FFFF);
        chk("sat_done_pulse", 32'(bus.DONE), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
